// File: rtl/usb_pe_tx_packet_gen.sv
// rtl/usb_pe_tx_packet_gen.sv - USB PE transmit packet generator (handshake, data + CRC16)
// Byte stream toward the SIE; the payload is pulled from a first-word-fall-through FIFO.
module usb_pe_tx_packet_gen #(
  parameter int MAX_PAYLOAD = 64,
  parameter int LEN_WID     = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic               clk48,
  input  logic               rst,
  input  logic               sendReq,
  input  logic [3:0]         sendPid,
  input  logic [LEN_WID-1:0] payloadLen,
  output logic               sendBusy,
  output logic               sendDone,
  output logic               sendError,
  output logic               srcUnderrun,
  input  logic               srcDataAvailable,
  input  logic [7:0]         srcData,
  output logic               srcPop,
  output logic               txReqSendPacket,
  output logic               txDataValid,
  output logic               txIsLastByte,
  output logic [7:0]         txData,
  input  logic               txAcceptNewData
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         pid_q, pid_d;
  logic [LEN_WID-1:0] len_q, len_d;
  logic [LEN_WID-1:0] cnt_q, cnt_d;
  logic [15:0]        crc_q, crc_d;
  logic               underrun_q, underrun_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               hs;
  logic               req_is_hs, req_is_data, req_len_ok;

  // CRC-16/USB byte update: reflected 0xA001, LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign req_is_hs   = (sendPid[1:0] == 2'b10);
  assign req_is_data = (sendPid[1:0] == 2'b11);
  assign req_len_ok  = (payloadLen <= LEN_WID'(MAX_PAYLOAD));

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pid_q      <= 4'h0;
      len_q      <= '0;
      cnt_q      <= '0;
      crc_q      <= 16'hFFFF;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pid_d           = pid_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    crc_d           = crc_q;
    underrun_d      = underrun_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    txData          = 8'h00;
    txDataValid     = 1'b0;
    txIsLastByte    = 1'b0;

    case (state_q)
      ST_PID: begin
        txData       = {~pid_q, pid_q};
        txDataValid  = 1'b1;
        txIsLastByte = (pid_q[1:0] == 2'b10);
      end
      ST_DATA: begin
        txData      = srcData;
        txDataValid = srcDataAvailable;
      end
      ST_CRC_LO: begin
        txData      = ~crc_q[7:0];
        txDataValid = 1'b1;
      end
      ST_CRC_HI: begin
        txData       = ~crc_q[15:8];
        txDataValid  = 1'b1;
        txIsLastByte = 1'b1;
      end
      default: ;
    endcase

    hs     = txDataValid && txAcceptNewData;
    srcPop = (state_q == ST_DATA) && hs;

    case (state_q)
      ST_IDLE: begin
        if (sendReq) begin
          if (req_is_hs) begin
            pid_d      = sendPid;
            underrun_d = 1'b0;
            state_d    = ST_PID;
          end else if (req_is_data && req_len_ok) begin
            pid_d      = sendPid;
            len_d      = payloadLen;
            crc_d      = 16'hFFFF;
            cnt_d      = '0;
            underrun_d = 1'b0;
            state_d    = ST_PID;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ST_PID: begin
        if (hs) begin
          if (pid_q[1:0] == 2'b10) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (len_q == '0) begin
            state_d = ST_CRC_LO;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // Starved FIFO: flag it and stall; a filler byte would corrupt the packet
        if (!srcDataAvailable) underrun_d = 1'b1;
        if (hs) begin
          crc_d = crc16_byte(crc_q, srcData);
          cnt_d = cnt_q + LEN_WID'(1);
          if (cnt_q == len_q - LEN_WID'(1)) state_d = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (hs) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        if (hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sendBusy        = (state_q != ST_IDLE);
    txReqSendPacket = sendBusy;
    sendDone        = done_q;
    sendError       = err_q;
    srcUnderrun     = underrun_q;
  end

endmodule

// File: tb/tb_usb_pe_tx_packet_gen.sv
// tb/tb_usb_pe_tx_packet_gen.sv - randomized self-checking bench for usb_pe_tx_packet_gen
// Reference: expected byte list and CRC built from packet rules; FIFO and SIE modelled with queues.
module tb_usb_pe_tx_packet_gen;

  localparam int LEN_WID = 7;

  logic               clk48 = 1'b0;
  logic               rst;
  logic               sendReq;
  logic [3:0]         sendPid;
  logic [LEN_WID-1:0] payloadLen;
  logic               sendBusy, sendDone, sendError, srcUnderrun;
  logic               srcDataAvailable;
  logic [7:0]         srcData;
  logic               srcPop;
  logic               txReqSendPacket, txDataValid, txIsLastByte;
  logic [7:0]         txData;
  logic               txAcceptNewData;

  usb_pe_tx_packet_gen #(.MAX_PAYLOAD(64), .LEN_WID(LEN_WID)) dut (
    .clk48(clk48), .rst(rst), .sendReq(sendReq), .sendPid(sendPid), .payloadLen(payloadLen),
    .sendBusy(sendBusy), .sendDone(sendDone), .sendError(sendError), .srcUnderrun(srcUnderrun),
    .srcDataAvailable(srcDataAvailable), .srcData(srcData), .srcPop(srcPop),
    .txReqSendPacket(txReqSendPacket), .txDataValid(txDataValid), .txIsLastByte(txIsLastByte),
    .txData(txData), .txAcceptNewData(txAcceptNewData)
  );

  always #5 clk48 = ~clk48;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int  last_cnt, last_idx, pop_cnt, done_cnt, err_cnt, busy_cycles;
  bit  rand_acc = 1'b0;
  bit  pop_seen = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] crc;
    logic fb;
    crc = 16'hFFFF;
    foreach (pay_q[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb  = crc[0] ^ pay_q[k][i];
        crc = {1'b0, crc[15:1]};
        if (fb) crc = crc ^ 16'hA001;
      end
    end
    return ~crc;
  endfunction

  // SIE / monitor side
  initial begin
    forever begin
      @(negedge clk48);
      pop_seen = srcPop;
      if (!rst) begin
        if (prev_stall)
          check("stall_hold", {txDataValid, txIsLastByte, txData}, {1'b1, prev_last, prev_data});
        if (txDataValid && txAcceptNewData) begin
          rx_q.push_back(txData);
          if (txIsLastByte) begin
            last_cnt++;
            last_idx = rx_q.size() - 1;
          end
        end
        if (srcPop) begin
          pop_cnt++;
          check("pop_needs_hs", txDataValid && txAcceptNewData, 1);
        end
        if (sendDone) done_cnt++;
        if (sendError) err_cnt++;
        if (sendBusy) busy_cycles++;
      end
      prev_stall = txDataValid && !txAcceptNewData && !rst;
      prev_data  = txData;
      prev_last  = txIsLastByte;
    end
  end

  // FIFO / back-pressure driver
  initial begin
    forever begin
      @(posedge clk48);
      #1;
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      srcDataAvailable = (fifo_q.size() > 0);
      srcData          = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      txAcceptNewData  = rand_acc ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic load(input int len);
    logic [7:0] b;
    pay_q.delete();
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pay_q.push_back(b);
      fifo_q.push_back(b);
    end
  endtask

  task automatic start_req(input logic [3:0] pid, input int len);
    rx_q.delete();
    last_cnt = 0; last_idx = -1; pop_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cycles = 0;
    @(posedge clk48); #1;
    sendReq = 1'b1; sendPid = pid; payloadLen = LEN_WID'(len);
    @(posedge clk48); #1;
    sendReq = 1'b0; sendPid = 4'($urandom); payloadLen = LEN_WID'($urandom);
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk48);
      if (sendDone) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk48);
      lat++;
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk48);
  endtask

  task automatic expect_packet(input string tag, input logic [3:0] pid);
    logic [15:0] crc;
    exp_q.delete();
    exp_q.push_back({~pid, pid});
    if (pid[1:0] == 2'b11) begin
      foreach (pay_q[k]) exp_q.push_back(pay_q[k]);
      crc = crc_model();
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    check({tag, "_last_cnt"}, last_cnt, 1);
    check({tag, "_last_pos"}, last_idx, exp_q.size() - 1);
    check({tag, "_pops"}, pop_cnt, (pid[1:0] == 2'b11) ? pay_q.size() : 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  logic [3:0] pid_tab [8] = '{4'b0010, 4'b1010, 4'b1110, 4'b0110, 4'b0011, 4'b1011, 4'b0111, 4'b1111};

  initial begin
    int lat;
    logic [3:0] pid;
    int len;
    rst = 1'b1; sendReq = 1'b0; sendPid = 4'h0; payloadLen = '0;
    srcDataAvailable = 1'b0; srcData = 8'h00; txAcceptNewData = 1'b1;
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    check("reset_outputs",
          {sendBusy, sendDone, sendError, srcUnderrun, srcPop, txReqSendPacket, txDataValid, txIsLastByte, txData}, 0);
    @(posedge clk48); #1;
    rst = 1'b0;

    // ACK
    start_req(4'b0010, 0);
    wait_done(lat);
    check("ack_latency", lat, 2);
    expect_packet("ack", 4'b0010);
    if (rx_q.size() > 0) check("ack_pid_byte", rx_q[0], 8'hD2);

    // DATA0, zero length
    pay_q.delete();
    start_req(4'b0011, 0);
    wait_done(lat);
    check("zlp_latency", lat, 4);
    expect_packet("zlp", 4'b0011);
    if (rx_q.size() == 3) check("zlp_bytes", {rx_q[0], rx_q[1], rx_q[2]}, 24'hC30000);

    // DATA1, "123456789", full rate then random back-pressure
    for (int pass = 0; pass < 2; pass++) begin
      pay_q.delete();
      for (int i = 0; i < 9; i++) begin
        pay_q.push_back(8'h31 + 8'(i));
        fifo_q.push_back(8'h31 + 8'(i));
      end
      rand_acc = (pass == 1);
      start_req(4'b1011, 9);
      wait_done(lat);
      if (pass == 0) check("d1_latency", lat, 13);
      expect_packet(pass ? "d1_stall" : "d1", 4'b1011);
      if (rx_q.size() == 12) check("d1_crc_bytes", {rx_q[10], rx_q[11]}, 16'hC8B4);
    end
    rand_acc = 1'b0;

    // FIFO runs dry after 3 of 5 bytes, refilled after 10 cycles
    pay_q.delete();
    for (int i = 0; i < 5; i++) pay_q.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) fifo_q.push_back(pay_q[i]);
    fork
      begin
        start_req(4'b0011, 5);
        wait_done(lat);
      end
      begin
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk48);
          if (srcUnderrun) begin
            hit = 1'b1;
            break;
          end
        end
        check("underrun_seen", hit, 1);
        repeat (10) @(negedge clk48);
        check("gap_valid_low", txDataValid, 0);
        check("gap_underrun", srcUnderrun, 1);
        check("gap_busy", sendBusy, 1);
        @(posedge clk48); #2;
        fifo_q.push_back(pay_q[3]);
        fifo_q.push_back(pay_q[4]);
      end
    join
    expect_packet("underrun", 4'b0011);
    check("underrun_sticky", srcUnderrun, 1);
    load(4);
    start_req(4'b0111, 4);
    wait_done(lat);
    expect_packet("after_underrun", 4'b0111);
    check("underrun_cleared", srcUnderrun, 0);

    // Rejected requests
    start_req(4'b0001, 0);
    wait_done(lat);
    check("rej_pid_latency", lat, 1);
    check("rej_pid_err", err_cnt, 1);
    check("rej_pid_done", done_cnt, 1);
    check("rej_pid_tx", rx_q.size() + busy_cycles + pop_cnt, 0);
    start_req(4'b0011, 65);
    wait_done(lat);
    check("rej_len_latency", lat, 1);
    check("rej_len_err", err_cnt, 1);
    check("rej_len_done", done_cnt, 1);
    check("rej_len_tx", rx_q.size() + busy_cycles + pop_cnt, 0);

    // Largest payload accepted
    load(64);
    start_req(4'b1111, 64);
    wait_done(lat);
    check("max_latency", lat, 68);
    expect_packet("max_len", 4'b1111);

    // Reset in the middle of DATA
    load(20);
    start_req(4'b0011, 20);
    repeat (4) @(posedge clk48);
    #1 rst = 1'b1;
    @(posedge clk48); #1;
    rst = 1'b0;
    @(negedge clk48);
    check("midrst_outputs",
          {sendBusy, sendDone, sendError, srcUnderrun, srcPop, txReqSendPacket, txDataValid, txIsLastByte, txData}, 0);
    lat = pop_cnt;
    repeat (5) @(negedge clk48);
    check("midrst_no_pop", pop_cnt, lat);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_last", last_cnt, 0);
    fifo_q.delete();
    start_req(4'b0010, 0);
    wait_done(lat);
    check("post_rst_ack_latency", lat, 2);
    expect_packet("post_rst_ack", 4'b0010);

    // Random packets
    for (int n = 0; n < 10; n++) begin
      pid = pid_tab[$urandom_range(0, 7)];
      len = $urandom_range(0, 64);
      rand_acc = 1'($urandom % 2);
      if (pid[1:0] == 2'b11) load(len);
      else pay_q.delete();
      start_req(pid, len);
      wait_done(lat);
      if (!rand_acc) check($sformatf("rnd%0d_latency", n), lat, (pid[1:0] == 2'b11) ? len + 4 : 2);
      expect_packet($sformatf("rnd%0d", n), pid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
